// File: rtl/mux_meter_pkg.sv
// Shared types and default constants for the mux output frequency meter.
package mux_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } meter_state_e;

    localparam int CNT_W_DEF       = 8;
    localparam int WIN_W_DEF       = 16;
    localparam int WINDOW_DEF      = 1000;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_CYCLES_DEF  = 4;

endpackage

// File: rtl/mux_out_freq_meter_if.sv
// Control/result bundle of the frequency meter: start request in, status and count out.
interface mux_out_freq_meter_if
    import mux_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count_q;
    logic             ovf;
    logic             edge_p;

    modport master (output start, input busy, done, count_q, ovf, edge_p);
    modport slave  (input start, output busy, done, count_q, ovf, edge_p);
endinterface

// File: rtl/mux_in_sync.sv
// Synchroniser, optional debounce filter and rising-edge detector for the mux output Y.
// Optional debounce filter is enabled by defining MUX_METER_DEBOUNCE_EN.
module mux_in_sync
    import mux_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic y_in,
    output logic edge_p
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   y_s;
    logic                   lvl;
    logic                   lvl_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], y_in};
        end
    end

    assign y_s = sync_q[SYNC_STAGES-1];

`ifdef MUX_METER_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt;
    logic             filt_q;

    // The level flips only after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q  <= 1'b0;
            deb_cnt <= '0;
        end else if (y_s == filt_q) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            filt_q  <= y_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = y_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_prev <= 1'b0;
            edge_p   <= 1'b0;
        end else begin
            lvl_prev <= lvl;
            edge_p   <= lvl & ~lvl_prev;
        end
    end

endmodule

// File: rtl/mux_out_freq_meter.sv
// Counts rising edges of the selected mux output over a fixed clk window on request.
// Optional debounce (MUX_METER_DEBOUNCE_EN) lives in mux_in_sync.
module mux_out_freq_meter
    import mux_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 y_in,
    mux_out_freq_meter_if.slave  bus
);

    if (WINDOW < 1 || WINDOW > (2 ** WIN_W) - 1) begin : g_bad_window
        $error("WINDOW must lie in 1..2^WIN_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);

    logic             edge_p;
    meter_state_e     state;
    logic [CNT_W-1:0] work_cnt;
    logic             ovf_int;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    mux_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_in_sync (
        .clk    (clk),
        .rst    (rst),
        .y_in   (y_in),
        .edge_p (edge_p)
    );

    assign bus.edge_p = edge_p;

    // Working count including this cycle's edge, so the final window cycle is captured.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        cnt_nxt = work_cnt;
        ovf_nxt = ovf_int;
        if (edge_p) begin
            if (work_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = work_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            work_cnt    <= '0;
            ovf_int     <= 1'b0;
            win_cnt     <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.count_q <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        work_cnt <= '0;
                        ovf_int  <= 1'b0;
                        win_cnt  <= WIN_LOAD;
                        bus.busy <= 1'b1;
                        state    <= MEASURE;
                    end
                end
                MEASURE: begin
                    work_cnt <= cnt_nxt;
                    ovf_int  <= ovf_nxt;
                    if (win_cnt == '0) begin
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.count_q <= cnt_nxt;
                        bus.ovf     <= ovf_nxt;
                        state       <= DONE;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_out_freq_meter.sv
// Randomised bench for mux_out_freq_meter: three parameterisations share y_in/start/rst
// and are compared every cycle with a window-sum reference model.
module tb_mux_out_freq_meter;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int NMAX = 4096;
    localparam int BASE = 16;

    int win_len [3] = '{16, 40, 1};
    int cnt_max [3] = '{255, 15, 255};

    logic clk;
    logic rst;
    logic y_in;
    logic start;

    mux_out_freq_meter_if #(.CNT_W(8)) bus_a ();
    mux_out_freq_meter_if #(.CNT_W(4)) bus_b ();
    mux_out_freq_meter_if #(.CNT_W(8)) bus_c ();

    assign bus_a.start = start;
    assign bus_b.start = start;
    assign bus_c.start = start;

    mux_out_freq_meter #(.CNT_W(8), .WINDOW(16), .WIN_W(16), .SYNC_STAGES(S), .DEB_CYCLES(D)) u_a (
        .clk(clk), .rst(rst), .y_in(y_in), .bus(bus_a)
    );
    mux_out_freq_meter #(.CNT_W(4), .WINDOW(40), .WIN_W(8), .SYNC_STAGES(S), .DEB_CYCLES(D)) u_b (
        .clk(clk), .rst(rst), .y_in(y_in), .bus(bus_b)
    );
    mux_out_freq_meter #(.CNT_W(8), .WINDOW(1), .WIN_W(4), .SYNC_STAGES(S), .DEB_CYCLES(D)) u_c (
        .clk(clk), .rst(rst), .y_in(y_in), .bus(bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n        = BASE;

    // Per-cycle history: y_in as sampled, conditioned level, expected edge_p.
    bit yh  [NMAX];
    bit lvl [NMAX];
    bit ep  [NMAX];

    // Per-instance expectation state.
    int ws    [3] = '{-1, -1, -1};
    int nok   [3] = '{0, 0, 0};
    int mcnt  [3] = '{0, 0, 0};
    bit movf  [3] = '{0, 0, 0};
    bit mbusy [3] = '{0, 0, 0};
    bit mdone [3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, n - BASE, got, exp);
        end
    endtask

    task automatic check_inst(input string nm, input int i, input logic b, input logic d,
                              input logic [31:0] c, input logic o, input logic e);
        check({nm, ".busy"},    32'(b), 32'(mbusy[i]));
        check({nm, ".done"},    32'(d), 32'(mdone[i]));
        check({nm, ".count_q"}, c,      32'(mcnt[i]));
        check({nm, ".ovf"},     32'(o), 32'(movf[i]));
        check({nm, ".edge_p"},  32'(e), 32'(ep[n]));
    endtask

    task automatic model_inst(input int i, input bit st, input bit r);
        int sum;
        if (r) begin
            ws[i]    = -1;
            nok[i]   = n + 1;
            mcnt[i]  = 0;
            movf[i]  = 1'b0;
            mbusy[i] = 1'b0;
            mdone[i] = 1'b0;
        end else begin
            mdone[i] = 1'b0;
            if (ws[i] >= 0 && n == ws[i] + win_len[i]) begin
                sum = 0;
                for (int m = ws[i]; m < ws[i] + win_len[i]; m++) sum += int'(ep[m]);
                mcnt[i]  = (sum > cnt_max[i]) ? cnt_max[i] : sum;
                movf[i]  = (sum > cnt_max[i]);
                mdone[i] = 1'b1;
                ws[i]    = -1;
            end
            if (ws[i] < 0 && st && n >= nok[i]) begin
                ws[i]  = n;
                nok[i] = n + win_len[i] + 2;
            end
            mbusy[i] = (ws[i] >= 0) && (n <= ws[i] + win_len[i] - 1);
        end
    endtask

    task automatic step(input bit y, input bit st, input bit r);
        bit all_diff;
        y_in  = y;
        start = st;
        rst   = r;
        @(posedge clk);
        #1;
        yh[n] = y;
        if (r) begin
            for (int m = n - S - D - 2; m <= n; m++) yh[m] = 1'b0;
            lvl[n] = 1'b0;
            ep[n]  = 1'b0;
        end else begin
            all_diff = 1'b1;
`ifdef MUX_METER_DEBOUNCE_EN
            for (int m = n - S - D + 1; m <= n - S; m++) begin
                if (yh[m] == lvl[n-1]) all_diff = 1'b0;
            end
            lvl[n] = all_diff ? yh[n-S] : lvl[n-1];
`else
            lvl[n] = all_diff & yh[n-S+1];
`endif
            ep[n] = lvl[n-1] & ~lvl[n-2];
        end
        for (int i = 0; i < 3; i++) model_inst(i, st, r);
        check_inst("a", 0, bus_a.busy, bus_a.done, 32'(bus_a.count_q), bus_a.ovf, bus_a.edge_p);
        check_inst("b", 1, bus_b.busy, bus_b.done, 32'(bus_b.count_q), bus_b.ovf, bus_b.edge_p);
        check_inst("c", 2, bus_c.busy, bus_c.done, 32'(bus_c.count_q), bus_c.ovf, bus_c.edge_p);
        n++;
    endtask

    initial begin
        bit yr;
        int run;
        y_in  = 1'b0;
        start = 1'b0;
        rst   = 1'b1;

        repeat (4) step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Constant low, then constant high.
        step(1'b0, 1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (60) step(1'b1, 1'b0, 1'b0);

        // Period-4 square wave started well before the request.
        for (int i = 0; i < 80; i++) step(bit'((i % 4) < 2), bit'(i == 12), 1'b0);

        // Period-2 wave saturates the 4-bit instance; then a quiet window clears it.
        for (int i = 0; i < 60; i++) step(bit'(i % 2), bit'(i == 4), 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, bit'(i == 10), 1'b0);

        // Requests while busy are dropped.
        for (int i = 0; i < 60; i++) step(bit'((i % 6) < 3), bit'(i == 0 || i == 3 || i == 10), 1'b0);

        // Start held high: back-to-back windows.
        for (int i = 0; i < 150; i++) step(bit'($urandom_range(0, 1)), 1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b0);

        // Reset in the fifth measuring cycle, then a clean window.
        for (int i = 0; i < 60; i++) step(bit'((i % 4) < 2), bit'(i == 2 || i == 20), bit'(i == 7));

        // Random run-length input with sporadic requests and resets.
        yr = 1'b0;
        run = 0;
        for (int i = 0; i < 2500; i++) begin
            if (run == 0) begin
                yr  = ~yr;
                run = int'($urandom_range(1, 8));
            end
            run--;
            step(yr, bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 399) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
